parameterization_div: RTL and testbench
=======================================

// Module: parameterization_div
// PURPOSE
// - N-lane SIMD bfloat16 divider: each lane computes c[i] = a[i] / b[i].
// - Lanes are independent, with one registered output stage.
// - Arithmetic building block for the BFloat16 vector datapath.
// - Sits beside the matching add and multiply blocks.
// PARAMETERS
// - N  default 2  number of 16-bit bfloat16 lanes; buses are 16*N bits wide.
// PORTS
// - clk    input   1       single clock; rising-edge active.
// - rst_n  input   1       reset, asynchronous and active-low.
// - a      input   16*N    dividends; lane i = a[16*i+15:16*i].
// - b      input   16*N    divisors; lane i = b[16*i+15:16*i].
// - c      output  16*N    quotients, registered; same lane mapping.
// BEHAVIOUR
// - Format per lane: bit 15 sign, [14:7] exponent (bias 127), [6:0] fraction.
// - Reset:
//   - rst_n low clears c to all zeros immediately (async).
//   - Release is synchronous to clk.
// - Latency: exactly 1 clk.
//   - A divide is computed combinationally from a and b sampled at a rising edge.
//   - It appears on c after that edge.
//   - A new operand pair is accepted every cycle. No handshake, no stall.
// - Sign: sa XOR sb, for all results including zero and inf.
// - Normal path:
//   - Form 8-bit mantissas {1,frac}.
//   - Quotient = ma/mb computed to at least 10 bits (7 kept + guard + round + sticky).
//   - Exponent = ea - eb + 127.
//   - If quotient < 1, shift left 1 and decrement exponent.
// - Rounding: round-to-nearest-even on the 7-bit fraction.
//   - Mantissa overflow from rounding increments the exponent.
// - Subnormal inputs (exp=0, frac!=0) are flushed to signed zero before use.
// - Result exponent >= 255: overflow to signed infinity (exp=FF, frac=0).
// - Result exponent <= 0: underflow to signed zero. No subnormal outputs.
// - Special cases, in priority order:
//   - Either operand NaN (exp=FF, frac!=0) -> canonical NaN 16'h7FC0.
//   - inf/inf or 0/0 -> 16'h7FC0.
//   - inf/finite -> signed inf.
//   - finite/inf -> signed zero.
//   - nonzero/0 -> signed inf.
//   - 0/nonzero -> signed zero.
// - Every lane uses identical logic; no interaction between lanes.
// - Operands changing mid-cycle affect only the next registered result.
// - rst_n asserted mid-stream discards the pending result; c reads 0 until the first edge after release.
// TESTING
// - Reset: rst_n=0 with arbitrary a,b -> c==0 on all lanes; hold 2 cycles, release -> results begin the next edge.
// - N=2, every lane a=16'hC170 (-15), b=16'h4120 (10) -> each lane c=16'hBFC0 (-1.5) one clk later.
// - N=2, every lane a=16'h4080 (4), b=16'h4040 (3) -> each lane c=16'h3FAB (1.3359, RNE round-up).
// - Mixed lanes, different pair per lane: 16'h3F80/16'h0000 -> 7F80; 16'h0000/16'h0000 -> 7FC0; 16'h7F80/16'h4000 -> 7F80; 16'h4000/16'h7F80 -> 0000.
// - Range: 16'h7F00/16'h3E80 -> 7F80 (overflow); 16'h0100/16'h7E00 -> 0000 (underflow); NaN input 16'h7FC1 -> 7FC0.
// - Back-to-back operand changes every cycle for 20 random pairs -> each c matches the reference model one cycle later.

Source files
------------

// File: rtl/parameterization_div.sv
// N-lane SIMD bfloat16 divider with one registered output stage.
// Each lane divides independently; subnormals flush to zero and no subnormals are produced.
module parameterization_div #(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [16*N-1:0] a,
    input  logic [16*N-1:0] b,
    output logic [16*N-1:0] c
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    logic [16*N-1:0] quot_s;
    logic [16*N-1:0] c_r;

    // Single-lane bfloat16 divide with RNE rounding and special-case handling.
    function automatic logic [15:0] bf16_div(input logic [15:0] x, input logic [15:0] y);
        logic              sr;
        logic [7:0]        ex;
        logic [7:0]        ey;
        logic              x_nan;
        logic              y_nan;
        logic              x_inf;
        logic              y_inf;
        logic              x_zero;
        logic              y_zero;
        logic [7:0]        mx;
        logic [7:0]        my;
        logic [18:0]       num;
        logic [11:0]       q;
        logic              rem_nz;
        logic [6:0]        frac;
        logic              g;
        logic              st;
        logic              rup;
        logic [8:0]        mant;
        logic [6:0]        frac_out;
        logic signed [9:0] e;
        logic [15:0]       res;

        sr     = x[15] ^ y[15];
        ex     = x[14:7];
        ey     = y[14:7];
        x_nan  = (ex == 8'hFF) && (x[6:0] != 7'd0);
        y_nan  = (ey == 8'hFF) && (y[6:0] != 7'd0);
        x_inf  = (ex == 8'hFF) && (x[6:0] == 7'd0);
        y_inf  = (ey == 8'hFF) && (y[6:0] == 7'd0);
        // exponent zero covers both true zero and flushed subnormals
        x_zero = (ex == 8'h00);
        y_zero = (ey == 8'h00);

        mx     = {1'b1, x[6:0]};
        my     = {1'b1, y[6:0]};
        num    = {mx, 11'd0};
        q      = 12'(num / {11'd0, my});
        rem_nz = |(num % {11'd0, my});
        e      = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;

        // q carries 11 fraction bits, so a sub-unity quotient still keeps guard and sticky
        if (q[11]) begin
            frac = q[10:4];
            g    = q[3];
            st   = (|q[2:0]) | rem_nz;
        end else begin
            frac = q[9:3];
            g    = q[2];
            st   = (|q[1:0]) | rem_nz;
            e    = e - 10'sd1;
        end

        rup  = g & (st | frac[0]);
        mant = {2'b01, frac} + {8'd0, rup};
        if (mant[8]) begin
            e        = e + 10'sd1;
            frac_out = 7'd0;
        end else begin
            frac_out = mant[6:0];
        end

        if (x_nan || y_nan) begin
            res = QNAN;
        end else if ((x_inf && y_inf) || (x_zero && y_zero)) begin
            res = QNAN;
        end else if (x_inf) begin
            res = {sr, 8'hFF, 7'd0};
        end else if (y_inf) begin
            res = {sr, 15'd0};
        end else if (y_zero) begin
            res = {sr, 8'hFF, 7'd0};
        end else if (x_zero) begin
            res = {sr, 15'd0};
        end else if (e >= 10'sd255) begin
            res = {sr, 8'hFF, 7'd0};
        end else if (e <= 10'sd0) begin
            res = {sr, 15'd0};
        end else begin
            res = {sr, e[7:0], frac_out};
        end
        return res;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign quot_s[16*i +: 16] = bf16_div(a[16*i +: 16], b[16*i +: 16]);
    end

    // Output register: one cycle of latency, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r <= '0;
        end else begin
            c_r <= quot_s;
        end
    end

    assign c = c_r;

endmodule

// File: tb/tb_parameterization_div.sv
// Directed and randomized self-checking bench for the 2-lane bfloat16 divider.
module tb_parameterization_div;

    localparam int N = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [16*N-1:0] a     = '0;
    logic [16*N-1:0] b     = '0;
    logic [16*N-1:0] c;

    int checks = 0;
    int errors = 0;

    parameterization_div #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16*N-1:0] expected);
        checks++;
        assert (c === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, c, expected);
        end
    endtask

    task automatic apply(input string tag, input logic [16*N-1:0] va,
                         input logic [16*N-1:0] vb, input logic [16*N-1:0] expected);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    // Reference for normal finite operands, computed with real arithmetic.
    function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
        real  q;
        real  s;
        real  fr;
        int   e;
        int   fl;
        logic sgn;
        sgn = x[15] ^ y[15];
        q   = real'(128 + int'(x[6:0])) / real'(128 + int'(y[6:0]));
        e   = int'(x[14:7]) - int'(y[14:7]) + 127;
        if (q < 1.0) begin
            q = q * 2.0;
            e = e - 1;
        end
        s  = q * 128.0;
        fl = $rtoi(s);
        fr = s - real'(fl);
        if (fr > 0.5 || (fr == 0.5 && fl[0])) fl = fl + 1;
        if (fl == 256) begin
            fl = 128;
            e  = e + 1;
        end
        if (e >= 255) return {sgn, 8'hFF, 7'd0};
        if (e <= 0) return {sgn, 15'd0};
        return {sgn, 8'(e), 7'(fl)};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v[15]   = 1'($urandom_range(0, 1));
        v[14:7] = 8'($urandom_range(64, 190));
        v[6:0]  = 7'($urandom_range(0, 127));
        return v;
    endfunction

    initial begin
        logic [15:0] ra0;
        logic [15:0] rb0;
        logic [15:0] ra1;
        logic [15:0] rb1;

        // reset with arbitrary operands
        a = 32'h1234_5678;
        b = 32'h4000_3F80;
        #2;
        check("reset_async", 32'h0);
        @(posedge clk); #1;
        check("reset_hold1", 32'h0);
        @(posedge clk); #1;
        check("reset_hold2", 32'h0);

        a = 32'hC170_C170;
        b = 32'h4120_4120;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", 32'h0);
        @(posedge clk); #1;
        check("neg15_div_10", 32'hBFC0_BFC0);

        apply("four_div_three", 32'h4080_4080, 32'h4040_4040, 32'h3FAB_3FAB);
        apply("one_div0_zero_div0", 32'h0000_3F80, 32'h0000_0000, 32'h7FC0_7F80);
        apply("inf_div_fin_fin_div_inf", 32'h4000_7F80, 32'h7F80_4000, 32'h0000_7F80);
        apply("overflow_underflow", 32'h0100_7F00, 32'h7E00_3E80, 32'h0000_7F80);
        apply("nan_inputs", 32'h3F80_7FC1, 32'h7FC1_3F80, 32'h7FC0_7FC0);
        apply("signed_specials", 32'h8000_BF80, 32'h3F80_0000, 32'h8000_FF80);

        // operands changing mid-cycle only affect the next result
        a = 32'h3F80_3F80;
        b = 32'h3F80_3F80;
        #3;
        a = 32'hC170_4080;
        b = 32'h4120_4040;
        @(posedge clk); #1;
        check("mid_cycle_change", 32'hBFC0_3FAB);

        // reset mid-stream drops the pending result
        a = 32'h4080_4080;
        b = 32'h4040_4040;
        #3;
        rst_n = 1'b0;
        #1;
        check("midstream_reset_async", 32'h0);
        @(posedge clk); #1;
        check("midstream_reset_hold", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_midstream_reset", 32'h3FAB_3FAB);

        for (int i = 0; i < 20; i++) begin
            ra0 = rand_op();
            rb0 = rand_op();
            ra1 = rand_op();
            rb1 = rand_op();
            apply($sformatf("random_%0d", i), {ra1, ra0}, {rb1, rb0},
                  {ref_div(ra1, rb1), ref_div(ra0, rb0)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
